// File: rtl/regfile_pkg.sv
// Shared widths, index/word types and fixed register indices for the
// multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ADR_WIDTH_DEFAULT  = 5;

  typedef logic [ADR_WIDTH_DEFAULT-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

  localparam int REG_ZERO        = 0;
  localparam int TAP_REG_DEFAULT = 10;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue,
// cleared by writeback, with set winning over clear on the same index.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_WIDTH_DEFAULT,
  parameter int NUM_RD    = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [1:0]                       we_i,
  input  logic [1:0][ADR_WIDTH-1:0]        wa_i,
  input  logic                             iss_i,
  input  logic [ADR_WIDTH-1:0]             iss_addr_i,
  input  logic [NUM_RD-1:0][ADR_WIDTH-1:0] ra_i,
  output logic [NUM_RD-1:0]                busy_o
);

  localparam int DEPTH = 2 ** ADR_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if ((we_i[0] && wa_i[0] == ADR_WIDTH'(i)) || (we_i[1] && wa_i[1] == ADR_WIDTH'(i)))
        w_busy_next[i] = 1'b0;
      if (iss_i && iss_addr_i == ADR_WIDTH'(i))
        w_busy_next[i] = 1'b1;
    end
    w_busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_next;
  end

  // A writeback landing this cycle already satisfies the reader via bypass.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_busy_rd
    logic w_hit;
    assign w_hit      = (we_i[0] && wa_i[0] == ra_i[gi]) || (we_i[1] && wa_i[1] == ra_i[gi]);
    assign busy_o[gi] = rst_ni && r_busy[ra_i[gi]] && !w_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with hard-wired zero register,
// same-cycle write-through bypass, a debug tap and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADR_WIDTH  = ADR_WIDTH_DEFAULT,
  parameter int NUM_RD     = 2,
  parameter int TAP_REG    = TAP_REG_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [1:0]                        we_i,
  input  logic [1:0][ADR_WIDTH-1:0]         wa_i,
  input  logic [1:0][DATA_WIDTH-1:0]        wd_i,
  input  logic [NUM_RD-1:0][ADR_WIDTH-1:0]  ra_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_o,
  output logic [NUM_RD-1:0]                 busy_o,
  input  logic                              iss_i,
  input  logic [ADR_WIDTH-1:0]              iss_addr_i,
  output logic [DATA_WIDTH-1:0]             tap_o
);

  localparam int DEPTH = 2 ** ADR_WIDTH;

  logic [DATA_WIDTH-1:0] w_regs [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] bypass(
    input logic                       rst_n,
    input logic [ADR_WIDTH-1:0]       a,
    input logic [1:0]                 we,
    input logic [1:0][ADR_WIDTH-1:0]  wa,
    input logic [1:0][DATA_WIDTH-1:0] wd,
    input logic [DATA_WIDTH-1:0]      stored
  );
    if (!rst_n || a == ADR_WIDTH'(REG_ZERO)) return '0;
    if (we[1] && wa[1] == a)                 return wd[1];
    if (we[0] && wa[0] == a)                 return wd[0];
    return stored;
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == REG_ZERO) begin : g_zero
      assign w_regs[gi] = '0;
    end else begin : g_word
      logic [DATA_WIDTH-1:0] r_q;
      // Port 1 (load) is checked first so it wins a same-index collision.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                    r_q <= '0;
        else if (we_i[1] && wa_i[1] == ADR_WIDTH'(gi)) r_q <= wd_i[1];
        else if (we_i[0] && wa_i[0] == ADR_WIDTH'(gi)) r_q <= wd_i[0];
      end
      assign w_regs[gi] = r_q;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rd_o[gi] = bypass(rst_ni, ra_i[gi], we_i, wa_i, wd_i, w_regs[ra_i[gi]]);
  end

  assign tap_o = bypass(rst_ni, ADR_WIDTH'(TAP_REG), we_i, wa_i, wd_i, w_regs[TAP_REG]);

  regfile_scoreboard #(
    .ADR_WIDTH (ADR_WIDTH),
    .NUM_RD    (NUM_RD)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .iss_i      (iss_i),
    .iss_addr_i (iss_addr_i),
    .ra_i       (ra_i),
    .busy_o     (busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scenarios plus random traffic checked against an array-based
// model of the register file and its pending-write scoreboard.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int TAP = 10;
  localparam int DEP = 2 ** AW;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [1:0]               we_i;
  logic [1:0][AW-1:0]       wa_i;
  logic [1:0][DW-1:0]       wd_i;
  logic [NR-1:0][AW-1:0]    ra_i;
  logic [NR-1:0][DW-1:0]    rd_o;
  logic [NR-1:0]            busy_o;
  logic                     iss_i;
  logic [AW-1:0]            iss_addr_i;
  logic [DW-1:0]            tap_o;

  word_t m_mem  [DEP];
  bit    m_busy [DEP];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_txn  = 0;

  always #5 clk_i = ~clk_i;

  regfile_mp #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .NUM_RD(NR), .TAP_REG(TAP)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .wd_i       (wd_i),
    .ra_i       (ra_i),
    .rd_o       (rd_o),
    .busy_o     (busy_o),
    .iss_i      (iss_i),
    .iss_addr_i (iss_addr_i),
    .tap_o      (tap_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hit(input int a);
    return (we_i[0] && int'(wa_i[0]) == a) || (we_i[1] && int'(wa_i[1]) == a);
  endfunction

  // Reader's view: zero register, then the newest write this cycle, then storage.
  function automatic word_t exp_rd(input int a);
    if (a == 0)                        return '0;
    if (we_i[1] && int'(wa_i[1]) == a) return wd_i[1];
    if (we_i[0] && int'(wa_i[0]) == a) return wd_i[0];
    return m_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEP; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (we_i[0]) begin m_mem[wa_i[0]] = wd_i[0]; m_busy[wa_i[0]] = 1'b0; end
    if (we_i[1]) begin m_mem[wa_i[1]] = wd_i[1]; m_busy[wa_i[1]] = 1'b0; end
    if (iss_i) m_busy[iss_addr_i] = 1'b1;
    m_mem[0]  = '0;
    m_busy[0] = 1'b0;
  endtask

  task automatic idle();
    we_i = '0; wa_i = '0; wd_i = '0; iss_i = 1'b0; iss_addr_i = '0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s rd%0d", tag, k), rd_o[k], exp_rd(int'(ra_i[k])));
      chk($sformatf("%s busy%0d", tag, k), busy_o[k], m_busy[ra_i[k]] && !hit(int'(ra_i[k])));
    end
    chk({tag, " tap"}, tap_o, exp_rd(TAP));
    n_txn++;
    $display("txn %0d %s we=%b wa=%0d/%0d ra=%0d/%0d iss=%b@%0d rd0=%h busy=%b tap=%h",
             n_txn, tag, we_i, wa_i[0], wa_i[1], ra_i[0], ra_i[1], iss_i, iss_addr_i,
             rd_o[0], busy_o, tap_o);
    @(posedge clk_i);
    model_commit();
    @(negedge clk_i);
  endtask

  initial begin
    model_clear();
    rst_ni = 1'b0;
    we_i = 2'b11; wa_i = {AW'(9), AW'(9)}; wd_i = {32'hBAD0BAD0, 32'h12345678};
    iss_i = 1'b1; iss_addr_i = AW'(9); ra_i = {AW'(9), AW'(TAP)};
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset rd0", rd_o[0], 0);
    chk("reset rd1", rd_o[1], 0);
    chk("reset busy", busy_o, 0);
    chk("reset tap", tap_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    ra_i = {AW'(9), AW'(9)};
    step("post-reset");

    we_i = 2'b01; wa_i[0] = 5; wd_i[0] = 32'hDEADBEEF; ra_i[0] = 5;
    step("wr5");
    idle(); ra_i[0] = 5;
    #1 chk("rd5 direct", rd_o[0], 32'hDEADBEEF);
    step("rd5");

    we_i = 2'b11; wa_i = {AW'(7), AW'(7)}; wd_i = {32'h2222, 32'h1111}; ra_i = {AW'(7), AW'(7)};
    #1 chk("collide bypass", rd_o[0], 32'h2222);
    step("wr7 both");
    idle();
    #1 chk("collide stored", rd_o[1], 32'h2222);
    step("rd7");

    we_i = 2'b01; wa_i[0] = 0; wd_i[0] = 32'hFFFFFFFF; ra_i = '0;
    step("wr0");
    idle(); ra_i = '0;
    step("rd0");

    iss_i = 1'b1; iss_addr_i = 3; ra_i[0] = 3;
    step("iss3");
    idle(); ra_i[0] = 3;
    #1 chk("busy3 set", busy_o[0], 1);
    step("busy3");
    we_i = 2'b01; wa_i[0] = 3; wd_i[0] = 32'h0000ABCD;
    #1 chk("busy3 wb", busy_o[0], 0);
    step("wb3");
    idle();
    step("after wb3");

    iss_i = 1'b1; iss_addr_i = 4; we_i = 2'b01; wa_i[0] = 4; wd_i[0] = 32'h44; ra_i[0] = 4;
    step("iss+wb4");
    idle(); ra_i[0] = 4;
    #1 chk("busy4 set wins", busy_o[0], 1);
    step("busy4");

    we_i = 2'b01; wa_i[0] = TAP; wd_i[0] = 32'h55;
    step("wr tap");
    idle();
    step("tap hold");
    #3 rst_ni = 1'b0;
    #1 chk("async tap", tap_o, 0);
    chk("async rd", rd_o, 0);
    chk("async busy", busy_o, 0);
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("tap cleared");

    for (int t = 0; t < 400; t++) begin
      for (int p = 0; p < 2; p++) begin
        we_i[p] = ($urandom_range(0, 2) != 0);
        wa_i[p] = AW'($urandom_range(0, 7));
        wd_i[p] = $urandom;
      end
      iss_i      = $urandom_range(0, 1);
      iss_addr_i = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEP - 1) : $urandom_range(0, 7));
      for (int k = 0; k < NR; k++) ra_i[k] = AW'($urandom_range(0, 11));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 SHALL have parameter ADR_WIDTH, default 5: register index width; depth is 2**ADR_WIDTH.
REQ-003 SHALL have parameter NUM_RD, default 2, range 1..4: number of read ports.
REQ-004 SHALL have parameter TAP_REG, default 10: index of the register mirrored on tap_o.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports we_i, input, [2]: per-write-port enable; port 0 is ALU writeback, port 1 is load writeback.
REQ-008 SHALL have ports wa_i, input, [2][ADR_WIDTH]: per-write-port destination index.
REQ-009 SHALL have ports wd_i, input, [2][DATA_WIDTH]: per-write-port data.
REQ-010 SHALL have ports ra_i, input, [NUM_RD][ADR_WIDTH]: read indices.
REQ-011 SHALL have ports rd_o, output, [NUM_RD][DATA_WIDTH]: read data.
REQ-012 SHALL have ports busy_o, output, [NUM_RD]: pending-write flag for each read index.
REQ-013 SHALL have port iss_i, input, 1: issue strobe marking iss_addr_i as pending.
REQ-014 SHALL have port iss_addr_i, input, [ADR_WIDTH]: destination index of the issued instruction.
REQ-015 SHALL have port tap_o, output, [DATA_WIDTH]: current value of register TAP_REG, with bypass applied.

Function
REQ-016 SHALL hold register 0 at 0: writes to index 0 are discarded, reads of index 0 return 0, busy for index 0 is always 0.
REQ-017 SHALL commit each enabled write port to its wa_i at the rising edge; latency is 1 cycle.
REQ-018 SHALL let port 1 win when both ports write the same nonzero index in one cycle.
REQ-019 SHALL make rd_o combinational, with same-cycle write-through bypass: if a write enable hits ra_i (nonzero), rd_o returns the wd_i of that port (port 1 priority), else the stored value.
REQ-020 SHALL apply the REQ-019 bypass to tap_o as well.
REQ-021 SHALL keep a scoreboard of one busy bit per register: iss_i sets busy[iss_addr_i] at the next edge; any write-port enable clears busy[wa_i] at the next edge.
REQ-022 SHALL give set priority over clear when the same index is issued and written back in the same cycle, so the bit stays 1.
REQ-023 SHALL drive busy_o combinationally: busy_o[k] = busy[ra_i[k]] AND NOT (a write enable hitting ra_i[k] this cycle), consistent with the bypass.
REQ-024 SHALL treat a duplicate iss_i on an already-busy index as a no-op (no counting); one writeback clears it.
REQ-025 SHALL let a writeback to a non-busy index still update data and leave busy at 0.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously clear all registers and all busy bits, independent of clk_i.
REQ-027 SHALL show these values during reset: rd_o=0, tap_o=0, busy_o=0.
REQ-028 SHALL discard writes and issues presented during reset; the first commit occurs at the first rising edge after rst_ni deasserts.

Structure
REQ-029 SHALL take from shared package regfile_pkg: DATA_WIDTH and ADR_WIDTH defaults, the reg_idx_t and word_t typedefs, and the REG_ZERO and TAP_REG_DEFAULT constants.
REQ-030 SHALL place busy-bit state and priority logic in the sub-module regfile_scoreboard, instantiated once.
REQ-031 SHALL keep the data array and bypass muxes in regfile_mp.

Verification
REQ-032 SHALL cover: reset, then we_i=01, wa_i[0]=5, wd_i[0]=0xDEADBEEF; next cycle ra_i[0]=5 -> rd_o[0]=0xDEADBEEF.
REQ-033 SHALL cover: same cycle, we_i=11, both wa_i=7, wd_i[0]=0x1111, wd_i[1]=0x2222 -> rd_o with ra=7 shows 0x2222 that cycle (bypass) and afterwards.
REQ-034 SHALL cover: write index 0 with 0xFFFFFFFF -> rd_o=0 and busy_o=0 for ra=0.
REQ-035 SHALL cover: iss_i with iss_addr_i=3 -> busy_o=1 for ra=3 next cycle; then writeback to 3 -> busy_o=0 in that same cycle and rd_o shows the written data.
REQ-036 SHALL cover: issue and writeback on index 4 in one cycle -> busy_o for ra=4 is 1 on the next cycle.
REQ-037 SHALL cover: write 0x55 to register 10, then pulse rst_ni low mid-cycle -> tap_o=0 immediately, without waiting for a clock edge.
